// File: rtl/uart_crc16_rx.sv
// UART receiver that reassembles 3-character frames (payload, CRC hi, CRC lo)
// and checks the payload against CRC-16/XMODEM.
module uart_crc16_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int GAP_TIMEOUT  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data_out,
  output logic       rx_ready_out,
  output logic       crc_valid_out,
  output logic       frame_err_out
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int GAP_CYC = GAP_TIMEOUT * CLKS_PER_BIT;
  localparam int GAP_W   = $clog2(GAP_CYC + 2);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LIM  = GAP_W'(GAP_CYC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] B_BYTE0 = 2'd0;
  localparam logic [1:0] B_BYTE1 = 2'd1;
  localparam logic [1:0] B_BYTE2 = 2'd2;

  // Bytewise CRC-16/XMODEM of a single byte from a zero seed.
  function automatic logic [15:0] crc16_byte(input logic [7:0] d);
    logic [15:0] c;
    c = {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]       vld_q, vld_d;
  logic             armed_q, armed_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       seq_q, seq_d;
  logic [7:0]       hold_q, hold_d;
  logic [15:0]      crc_q, crc_d;
  logic [7:0]       hi_q, hi_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             rx_s, char_done, char_err, gap_hit;

  assign rx_s          = sync2_q;
  assign rx_data_out   = data_q;
  assign rx_ready_out  = ready_q;
  assign crc_valid_out = valid_q;
  assign frame_err_out = err_q;

  // Next-state logic for the synchroniser, bit FSM and frame sequencer.
  always_comb begin
    sync1_d   = rx_in;
    sync2_d   = sync1_q;
    vld_d     = {vld_q[0], 1'b1};
    armed_d   = armed_q | (rx_s & vld_q[1]);
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    seq_d     = seq_q;
    hold_d    = hold_q;
    crc_d     = crc_q;
    hi_d      = hi_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    char_done = 1'b0;
    char_err  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        if (armed_q && !rx_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = CNT_ZERO;
          bit_idx_d = 3'd0;
          if (rx_s) begin
            state_d  = S_IDLE;
            char_err = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = CNT_ZERO;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = CNT_ZERO;
          state_d = S_IDLE;
          if (rx_s) begin
            char_done = 1'b1;
          end else begin
            char_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Inter-character idle time is only policed once a frame is underway.
    if (state_q == S_IDLE && seq_q != B_BYTE0) begin
      gap_d = gap_q + GAP_ONE;
    end else begin
      gap_d = GAP_ZERO;
    end
    gap_hit = (state_q == S_IDLE) && (seq_q != B_BYTE0) && (gap_q == GAP_LIM);

    if (char_err || gap_hit) begin
      err_d = 1'b1;
      seq_d = B_BYTE0;
    end else if (char_done) begin
      case (seq_q)
        B_BYTE0: begin
          hold_d = shift_q;
          crc_d  = crc16_byte(shift_q);
          seq_d  = B_BYTE1;
        end
        B_BYTE1: begin
          hi_d  = shift_q;
          seq_d = B_BYTE2;
        end
        B_BYTE2: begin
          data_d  = hold_q;
          valid_d = ({hi_q, shift_q} == crc_q);
          ready_d = 1'b1;
          seq_d   = B_BYTE0;
        end
        default: begin
          seq_d = B_BYTE0;
        end
      endcase
    end else begin
      seq_d = seq_q;
    end
  end

  // State registers; the synchroniser resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      vld_q     <= 2'b00;
      armed_q   <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      seq_q     <= B_BYTE0;
      hold_q    <= 8'h00;
      crc_q     <= 16'h0000;
      hi_q      <= 8'h00;
      gap_q     <= GAP_ZERO;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      vld_q     <= vld_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      seq_q     <= seq_d;
      hold_q    <= hold_d;
      crc_q     <= crc_d;
      hi_q      <= hi_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_crc16_rx.sv
// Directed bench for uart_crc16_rx: frames are driven serially and every
// expected ready/error pulse is queued with its exact cycle and held outputs.
module tb_uart_crc16_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data_out;
  logic       rx_ready_out;
  logic       crc_valid_out;
  logic       frame_err_out;

  typedef struct {
    logic       is_err;
    int         cyc;
    logic [7:0] data;
    logic       valid;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         cyc;
  int         compared;
  int         mismatched;
  logic [7:0] exp_data;
  logic       exp_valid;

  uart_crc16_rx #(.CLKS_PER_BIT(CPB), .GAP_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_data_out  (rx_data_out),
    .rx_ready_out (rx_ready_out),
    .crc_valid_out(crc_valid_out),
    .frame_err_out(frame_err_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit-serial CRC-16/XMODEM reference.
  function automatic logic [15:0] crc_model(input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
    end
  endtask

  // Called at a negedge; start bit begins at that negedge.
  task automatic send_char(input logic [7:0] b, input int stop_len, input logic stop_val);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = stop_val;
    repeat (stop_len) @(negedge clk);
    rx_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [15:0] crc,
                            input int stop_len, input int last_stop_len);
    ev_t e;
    send_char(d, stop_len, 1'b1);
    send_char(crc[15:8], stop_len, 1'b1);
    exp_data  = d;
    exp_valid = (crc == crc_model(d));
    e = '{1'b0, cyc + 155, d, exp_valid};
    exp_q.push_back(e);
    send_char(crc[7:0], last_stop_len, 1'b1);
  endtask

  task automatic expect_err(input int at_cyc);
    ev_t e;
    e = '{1'b1, at_cyc, exp_data, exp_valid};
    exp_q.push_back(e);
  endtask

  // Scoreboard: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rx_ready_out || frame_err_out) begin
      chk("ready_and_err_exclusive", 32'(rx_ready_out & frame_err_out), 32'd0);
      chk("event_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("event_kind_err", 32'(frame_err_out), 32'(mon_e.is_err));
        chk("event_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("rx_data_out", 32'(rx_data_out), 32'(mon_e.data));
        chk("crc_valid_out", 32'(crc_valid_out), 32'(mon_e.valid));
      end
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_data   = 8'h00;
    exp_valid  = 1'b0;
    reset      = 1'b1;
    rx_in      = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_data", 32'(rx_data_out), 32'h00);
    chk("reset_ready", 32'(rx_ready_out), 32'd0);
    chk("reset_valid", 32'(crc_valid_out), 32'd0);
    chk("reset_err", 32'(frame_err_out), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Good frame.
    send_frame(8'hAA, 16'h14A0, 16, 16);
    repeat (32) @(negedge clk);

    // Back-to-back frames with shortened stop bits.
    send_frame(8'hFF, 16'h1EF0, 12, 12);
    send_frame(8'h00, 16'h0000, 12, 16);
    repeat (32) @(negedge clk);

    // Corrupted CRC.
    send_frame(8'hAA, 16'h14A1, 16, 16);
    repeat (32) @(negedge clk);

    // Bad stop bit on the CRC high character, then a good frame.
    send_char(8'hAA, 16, 1'b1);
    expect_err(cyc + 155);
    send_char(8'h14, 9, 1'b0);
    repeat (32) @(negedge clk);
    send_frame(8'hFF, 16'h1EF0, 16, 16);
    repeat (32) @(negedge clk);

    // Payload only, then idle past the gap timeout.
    expect_err(cyc + 220);
    send_char(8'h5A, 16, 1'b1);
    repeat (80) @(negedge clk);

    // Three-cycle glitch is a false start.
    expect_err(cyc + 11);
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (32) @(negedge clk);

    // Reset in the middle of the CRC high character with the line held low.
    send_char(8'h11, 16, 1'b1);
    rx_in = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("midreset_data", 32'(rx_data_out), 32'h00);
    chk("midreset_ready", 32'(rx_ready_out), 32'd0);
    chk("midreset_valid", 32'(crc_valid_out), 32'd0);
    chk("midreset_err", 32'(frame_err_out), 32'd0);
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    reset = 1'b0;
    repeat (40) @(negedge clk);
    rx_in = 1'b1;
    repeat (48) @(negedge clk);
    send_frame(8'hAA, 16'h14A0, 16, 16);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_crc16_rx.md
# uart_crc16_rx

UART receiver with CRC-16 frame checking. It is the receiving end of the CRC-protected UART link: it deserialises the line, reassembles each 3-character frame, recomputes CRC-16/XMODEM over the payload byte and reports the payload together with a validity flag. Upstream is the serial line from the CRC-appending transmitter. Downstream is the consumer of `rx_data_out`, `rx_ready_out` and `crc_valid_out`.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit. Even, ≥ 4.
- `GAP_TIMEOUT`, 4: maximum idle bit-times allowed between the characters of one frame.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `rx_in`  in  1  asynchronous serial line; idles high.
- `rx_data_out`  out  8  payload byte of the last completed frame.
- `rx_ready_out`  out  1  one-cycle pulse when a frame completes.
- `crc_valid_out`  out  1  CRC result of the last completed frame; held until the next completion.
- `frame_err_out`  out  1  one-cycle pulse on a bad stop bit, a false start or a gap timeout.

## Operation
- Frame format: three characters in order: payload D, CRC high byte, CRC low byte.
- Character format: 1 start bit (0), 8 data bits sent LSB first, 1 stop bit (1).
- CRC definition: CRC-16/XMODEM over D only. Polynomial 0x1021, initial value 0x0000, MSB first, no reflection, no final XOR.
- Input synchronisation: `rx_in` passes through a 2-flop synchroniser. All logic below uses the synchronised signal.
- Bit FSM states and transitions:
  - IDLE → START when the synchronised line reads 0.
  - START: sample at count CLKS_PER_BIT/2−1. If the sample is 1, it is a false start: return to IDLE and pulse `frame_err_out`. If 0, go to DATA.
  - DATA: take 8 samples, each CLKS_PER_BIT cycles apart, shifting in LSB first. Then go to STOP.
  - STOP: sample once, CLKS_PER_BIT after the last data sample. A 0 is a framing error: pulse `frame_err_out`, discard the frame, go to IDLE. A 1 means the character is complete; go to IDLE.
- Frame sequencer states BYTE0 → BYTE1 → BYTE2 → BYTE0:
  - On BYTE0 completion, latch D into a holding register and compute crc = CRC16(D) with a combinational bytewise engine.
  - On BYTE1 completion, latch the CRC high byte.
  - On BYTE2 completion:
    - Load `rx_data_out` with D.
    - Set `crc_valid_out` = ({hi, lo} == crc).
    - Pulse `rx_ready_out`.
- `rx_data_out` is updated even when the CRC is bad.
- Gap timeout: applies only in BYTE1 and BYTE2. If the bit FSM stays in IDLE for more than GAP_TIMEOUT×CLKS_PER_BIT cycles, pulse `frame_err_out` and return the sequencer to BYTE0.
- Any error returns the sequencer to BYTE0. `rx_data_out` and `crc_valid_out` keep their previous values on error.

## Timing
- Reset values:
  - `rx_data_out` = 0x00, `rx_ready_out` = 0, `crc_valid_out` = 0, `frame_err_out` = 0.
  - FSMs in IDLE/BYTE0, synchroniser flops at 1.
- Reset mid-frame discards the partial frame.
- After reset, start detection is armed only once the synchronised line has read 1 for at least one cycle. A low line at reset release is not treated as a start.
- Start-bit sample point: cycle CLKS_PER_BIT/2 after the first synchronised 0. This cycle is 2 cycles after the raw falling edge plus the count.
- Stop-bit sample point: CLKS_PER_BIT/2 + 9×CLKS_PER_BIT cycles after start detect.
- `rx_ready_out` and the `rx_data_out`/`crc_valid_out` update are registered. They are asserted in the cycle after the BYTE2 stop sample.
- `frame_err_out` is asserted in the cycle after the failing sample or the timeout.
- Back-to-back characters: the next start bit may begin right after the stop sample (half a stop bit early). START must still detect it.
- `rx_ready_out` and `frame_err_out` are never high in the same cycle.

## Test plan
- Send frame D=0xAA, CRC=0x14A0, with CLKS_PER_BIT=16 → one `rx_ready_out` pulse, `rx_data_out`=0xAA, `crc_valid_out`=1, no `frame_err_out`.
- Send frame D=0xFF, CRC=0x1EF0, back-to-back with D=0x00, CRC=0x0000 and zero idle between characters → two ready pulses, with data 0xFF then 0x00 and `crc_valid_out`=1 both times.
- Send D=0xAA with CRC 0x14A1 (one bit flipped) → ready pulse, `rx_data_out`=0xAA, `crc_valid_out`=0.
- Force the stop bit of the CRC-high character to 0 → `frame_err_out` pulse, no ready pulse. A following good frame 0xFF/0x1EF0 is received correctly.
- Send D only, then idle 5 bit-times → `frame_err_out` pulse at 4×16+1 cycles after IDLE entry. The sequencer returns to BYTE0 and outputs are unchanged.
- Pulse `rx_in` low for 3 cycles (glitch) → false start, `frame_err_out` pulse. Separately, assert reset during the data bits of BYTE1 → all outputs go to reset values and the next frame is received cleanly.
